// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared constants and types for the vga text-mode write feeder.
//   - Screen geometry (COLS x ROWS character cells) and write address width.
//   - Fill byte used for clears and backspace.
//   - ASCII control codes interpreted by the feeder.
//   - FSM state enum. The LCLEAR state only exists when the line-clear
//     feature is built in (macro VGA_TEXT_WRITER_LINE_CLEAR_EN).
// -----------------------------------------------------------------------------
package vga_text_pkg;

  localparam int COLS       = 160;
  localparam int ROWS       = 128;
  localparam int ADDR_WIDTH = 15;
  localparam int COL_W      = $clog2(COLS);
  localparam int ROW_W      = $clog2(ROWS);

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] CELL_LAST = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(COLS);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
    ,
    LCLEAR = 2'd2
`endif
  } state_e;

  // Bytes that are drawn as glyphs; everything else is a control code or ignored.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// -----------------------------------------------------------------------------
// vga_text_cursor
// Cursor position tracker for the text writer. Holds col, row and row_base
// (= row*COLS, kept as a running sum so no multiplier is needed).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   inc               advance one cell (wraps to next row, row wraps to 0)
//   newline           col=0 and advance one row
//   cr                col=0
//   bs                col-1 when col>0 (no reverse line wrap)
//   home              col=0, row=0
//   col               current column
//   next_row_base     base address of the row after the current one
//                     (0 when the current row is the last one)
//   cursor_addr       registered row_base+col, valid the cycle after a control
// Controls are mutually exclusive; home has priority.
// Build option: VGA_TEXT_WRITER_LINE_CLEAR_EN does not change this module.
// -----------------------------------------------------------------------------
module vga_text_cursor
  import vga_text_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  newline,
  input  logic                  cr,
  input  logic                  bs,
  input  logic                  home,
  output logic [COL_W-1:0]      col,
  output logic [ADDR_WIDTH-1:0] next_row_base,
  output logic [ADDR_WIDTH-1:0] cursor_addr
);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] cursor_addr_q, cursor_addr_d;
  logic                  row_adv;

  // Depends on state only, so the top can use it without a combinational loop.
  assign next_row_base = (row_q == ROW_LAST) ? '0 : row_base_q + ROW_STEP;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    row_adv    = 1'b0;

    if (home) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = '0;
    end else if (newline) begin
      col_d   = '0;
      row_adv = 1'b1;
    end else if (inc) begin
      if (col_q == COL_LAST) begin
        col_d   = '0;
        row_adv = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (cr) begin
      col_d = '0;
    end else if (bs && (col_q != '0)) begin
      col_d = col_q - 1'b1;
    end

    // No scrolling: the last row wraps back to the top of the buffer.
    if (row_adv) begin
      row_base_d = next_row_base;
      row_d      = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    cursor_addr_d = row_base_d + ADDR_WIDTH'(col_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q         <= '0;
      row_q         <= '0;
      row_base_q    <= '0;
      cursor_addr_q <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      row_base_q    <= row_base_d;
      cursor_addr_q <= cursor_addr_d;
    end
  end

  assign col         = col_q;
  assign cursor_addr = cursor_addr_q;

endmodule

// File: rtl/vga_text_writer.sv
// -----------------------------------------------------------------------------
// vga_text_writer
// Converts a valid/ready ASCII byte stream into character-buffer writes.
// Handles printable bytes, LF, CR, BS and FF (full-screen clear); other bytes
// are consumed silently. A full clear runs out of reset.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   in_valid      in_char holds a byte
//   in_ready      byte accepted on this edge when in_valid is also high
//   in_char       ASCII byte
//   wr_en         one-cycle buffer write strobe
//   data_addr     write address (row*COLS + col)
//   data_out      write data
//   cursor_addr   current cursor cell, for the cursor overlay
//   busy          clear / line-clear sequence in progress
// All outputs are registered; writes appear the cycle after the accepting edge.
// Build option: define VGA_TEXT_WRITER_LINE_CLEAR_EN to blank each new row
// (LCLEAR state) whenever the cursor advances to it.
// -----------------------------------------------------------------------------
module vga_text_writer
  import vga_text_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_char,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [7:0]            data_out,
  output logic [ADDR_WIDTH-1:0] cursor_addr,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
  logic [COL_W-1:0]      lcnt_q, lcnt_d;
`endif

  logic                  cur_inc, cur_newline, cur_cr, cur_bs, cur_home;
  logic [COL_W-1:0]      cur_col;
  logic [ADDR_WIDTH-1:0] cur_next_row_base;
  logic [ADDR_WIDTH-1:0] cur_addr;

  vga_text_cursor u_cursor (
    .clk           (clk),
    .reset         (reset),
    .inc           (cur_inc),
    .newline       (cur_newline),
    .cr            (cur_cr),
    .bs            (cur_bs),
    .home          (cur_home),
    .col           (cur_col),
    .next_row_base (cur_next_row_base),
    .cursor_addr   (cur_addr)
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    wr_en_d     = 1'b0;
    data_addr_d = data_addr_q;
    data_out_d  = data_out_q;
    cur_inc     = 1'b0;
    cur_newline = 1'b0;
    cur_cr      = 1'b0;
    cur_bs      = 1'b0;
    cur_home    = 1'b0;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
    lcnt_d      = lcnt_q;
`endif

    case (state_q)
      CLEAR: begin
        wr_en_d     = 1'b1;
        data_addr_d = clr_addr_q;
        data_out_d  = BLANK_CHAR;
        if (clr_addr_q == CELL_LAST) begin
          clr_addr_d = '0;
          cur_home   = 1'b1;
          state_d    = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end

      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (is_printable(in_char)) begin
            // cursor_addr already equals row_base+col, so it is the write address.
            wr_en_d     = 1'b1;
            data_addr_d = cur_addr;
            data_out_d  = in_char;
            cur_inc     = 1'b1;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
            if (cur_col == COL_LAST) begin
              state_d    = LCLEAR;
              clr_addr_d = cur_next_row_base;
              lcnt_d     = '0;
            end
`endif
          end else begin
            case (in_char)
              CH_LF: begin
                cur_newline = 1'b1;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
                state_d    = LCLEAR;
                clr_addr_d = cur_next_row_base;
                lcnt_d     = '0;
`endif
              end
              CH_CR: cur_cr = 1'b1;
              CH_BS: begin
                // Blank the cell the cursor steps back onto; col 0 is a no-op.
                if (cur_col != '0) begin
                  cur_bs      = 1'b1;
                  wr_en_d     = 1'b1;
                  data_addr_d = cur_addr - 1'b1;
                  data_out_d  = BLANK_CHAR;
                end
              end
              CH_FF: begin
                clr_addr_d = '0;
                state_d    = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
      LCLEAR: begin
        wr_en_d     = 1'b1;
        data_addr_d = clr_addr_q;
        data_out_d  = BLANK_CHAR;
        clr_addr_d  = clr_addr_q + 1'b1;
        lcnt_d      = lcnt_q + 1'b1;
        if (lcnt_q == COL_LAST) begin
          clr_addr_d = '0;
          state_d    = IDLE;
        end
      end
`endif

      default: state_d = CLEAR;
    endcase

    // Registered from the next state so in_ready always mirrors state==IDLE.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      data_addr_q <= '0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
      lcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      wr_en_q     <= wr_en_d;
      data_addr_q <= data_addr_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
      lcnt_q      <= lcnt_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign data_addr   = data_addr_q;
  assign data_out    = data_out_q;
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign cursor_addr = cur_addr;

endmodule

// File: tb/tb_vga_text_writer.sv
// -----------------------------------------------------------------------------
// tb_vga_text_writer
// Directed bench for vga_text_writer: table of single-byte vectors with
// hand-computed write/cursor results plus hand-written multi-cycle sequences
// (power-up clear, full-row fill, row-127 wrap, reset during FF clear).
// -----------------------------------------------------------------------------
module tb_vga_text_writer;

  localparam int NCELL = 20480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] data_addr;
  logic [7:0]  data_out;
  logic [14:0] cursor_addr;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  vga_text_writer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .wr_en       (wr_en),
    .data_addr   (data_addr),
    .data_out    (data_out),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  data;
    logic [14:0] cur;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one byte, wait (bounded) for in_ready, return #1 after the accepting edge.
  task automatic send(input logic [7:0] ch);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    in_char  = ch;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    send(v.ch);
    chk($sformatf("%s_wr", tag), 32'(wr_en), 32'(v.wr));
    if (v.wr) begin
      chk($sformatf("%s_addr", tag), 32'(data_addr), 32'(v.addr));
      chk($sformatf("%s_data", tag), 32'(data_out), 32'(v.data));
    end
    chk($sformatf("%s_cursor", tag), 32'(cursor_addr), 32'(v.cur));
  endtask

  // Expects a full-screen clear starting at the next rising edge.
  task automatic check_clear(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < NCELL; i++) begin
      @(posedge clk);
      #1;
      if (!(wr_en === 1'b1 && data_addr === 15'(i) && data_out === 8'h20)) errs++;
      if (i < NCELL - 1 && (busy !== 1'b1 || in_ready !== 1'b0)) errs++;
    end
    chk($sformatf("%s_seq", name), 32'(errs), 32'd0);
    chk($sformatf("%s_ready", name), 32'(in_ready), 32'd1);
    chk($sformatf("%s_busy", name), 32'(busy), 32'd0);
  endtask

  vec_t ta[13];
  vec_t tb[4];

  initial begin
    int errs;

    //              ch     wr    addr     data   cursor
    ta[0]  = '{8'h41, 1'b1, 15'd0, 8'h41, 15'd1};
    ta[1]  = '{8'h45, 1'b1, 15'd1, 8'h45, 15'd2};
    ta[2]  = '{8'h45, 1'b1, 15'd2, 8'h45, 15'd3};
    ta[3]  = '{8'h45, 1'b1, 15'd3, 8'h45, 15'd4};
    ta[4]  = '{8'h45, 1'b1, 15'd4, 8'h45, 15'd5};
    ta[5]  = '{8'h08, 1'b1, 15'd4, 8'h20, 15'd4};   // BS at col 5
    ta[6]  = '{8'h0D, 1'b0, 15'd0, 8'h00, 15'd0};   // CR
    ta[7]  = '{8'h08, 1'b0, 15'd0, 8'h00, 15'd0};   // BS at col 0: no-op
    ta[8]  = '{8'h07, 1'b0, 15'd0, 8'h00, 15'd0};   // BEL ignored
    ta[9]  = '{8'h7F, 1'b0, 15'd0, 8'h00, 15'd0};   // DEL ignored
    ta[10] = '{8'hFF, 1'b0, 15'd0, 8'h00, 15'd0};   // high byte ignored
    ta[11] = '{8'h7E, 1'b1, 15'd0, 8'h7E, 15'd1};   // top printable
    ta[12] = '{8'h0D, 1'b0, 15'd0, 8'h00, 15'd0};

    tb[0]  = '{8'h43, 1'b1, 15'd160, 8'h43, 15'd161};
    tb[1]  = '{8'h0D, 1'b0, 15'd0,   8'h00, 15'd160};
    tb[2]  = '{8'h0A, 1'b0, 15'd0,   8'h00, 15'd320};
    tb[3]  = '{8'h44, 1'b1, 15'd320, 8'h44, 15'd321};

    // Reset values
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_data_addr", 32'(data_addr), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_cursor", 32'(cursor_addr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Power-up clear
    @(negedge clk);
    reset = 1'b1;
    check_clear("clear0");
    chk("clear0_cursor", 32'(cursor_addr), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_no_write", 32'(wr_en), 32'd0);

    for (int i = 0; i < 13; i++) apply(ta[i], $sformatf("ta%0d", i));

    // Fill row 0 completely; the last cell wraps the cursor to row 1
    errs = 0;
    for (int i = 0; i < 160; i++) begin
      send(8'h42);
      if (!(wr_en === 1'b1 && data_addr === 15'(i) && data_out === 8'h42)) errs++;
    end
    chk("fill_row0", 32'(errs), 32'd0);
    chk("fill_row0_cursor", 32'(cursor_addr), 32'd160);

    for (int i = 0; i < 4; i++) apply(tb[i], $sformatf("tb%0d", i));

    // Walk to row 127, fill to col 159, then LF wraps the cursor to cell 0
    send(8'h0D);
    for (int i = 0; i < 125; i++) send(8'h0A);
    chk("row127_cursor", 32'(cursor_addr), 32'd20320);
    errs = 0;
    for (int i = 0; i < 159; i++) begin
      send(8'h2E);
      if (!(wr_en === 1'b1 && data_addr === 15'(20320 + i) && data_out === 8'h2E)) errs++;
    end
    chk("fill_row127", 32'(errs), 32'd0);
    chk("last_cell_cursor", 32'(cursor_addr), 32'd20479);
    send(8'h0A);
    chk("lf_wrap_wr", 32'(wr_en), 32'd0);
    chk("lf_wrap_cursor", 32'(cursor_addr), 32'd0);
`ifdef VGA_TEXT_WRITER_LINE_CLEAR_EN
    chk("lclear_ready", 32'(in_ready), 32'd0);
    errs = 0;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      #1;
      if (!(wr_en === 1'b1 && data_addr === 15'(i) && data_out === 8'h20)) errs++;
      if (i < 159 && (in_ready !== 1'b0 || busy !== 1'b1)) errs++;
    end
    chk("lclear_seq", 32'(errs), 32'd0);
`endif

    // FF starts a clear; reset 100 cycles in restarts it from address 0
    send(8'h0C);
    chk("ff_wr", 32'(wr_en), 32'd0);
    chk("ff_busy", 32'(busy), 32'd1);
    chk("ff_ready", 32'(in_ready), 32'd0);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!(wr_en === 1'b1 && data_addr === 15'(i) && data_out === 8'h20)) errs++;
    end
    chk("ff_clear_head", 32'(errs), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_addr", 32'(data_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd0);

    // Byte held valid across the restarted clear is taken on the first IDLE cycle
    in_char  = 8'h5A;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_clear("clear1");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("held_wr", 32'(wr_en), 32'd1);
    chk("held_addr", 32'(data_addr), 32'd0);
    chk("held_data", 32'(data_out), 32'h5A);
    chk("held_cursor", 32'(cursor_addr), 32'd1);

    send(8'h07);
    chk("bel_wr", 32'(wr_en), 32'd0);
    chk("bel_cursor", 32'(cursor_addr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
